fence_t_sequencer: RTL

- Parametrised temporal-fence (fence.t) sequencer. It replaces the single-source, single-cache-port fence.t FSM inside the flush controller.
- Sequence: flush caches, drain N handshaked ports, pad to a deadline from a selectable trigger source, pulse micro-architectural reset, then hold cache-init suppression.
- Adds over the previous generation: trigger arming (padding never ends before a trigger is seen), per-fence deadline-miss detection with a saturating miss counter, and programmable drain/reset/init lengths.
- Sits beside the flush controller, between commit/CSR and the cache subsystem.

---
 rtl/fence_t_sequencer_pkg.sv | 16 +
 rtl/fence_t_sequencer_if.sv | 23 ++
 rtl/fence_t_sequencer_counter.sv | 32 +++
 rtl/fence_t_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fence_t_sequencer_pkg.sv
// rtl/fence_t_sequencer_pkg.sv - shared types for the temporal-fence sequencer
package fence_t_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        DRAIN = 3'd2,
        PAD   = 3'd3,
        RST   = 3'd4
    } fence_t_state_e;

    localparam int MISS_CNT_W = 16;
    typedef logic [MISS_CNT_W-1:0] miss_cnt_t;
    localparam miss_cnt_t MISS_CNT_MAX = '1;

endpackage

// File: rtl/fence_t_sequencer_if.sv
// rtl/fence_t_sequencer_if.sv - cache flush handshake and drain-port busy bundle
interface fence_t_sequencer_if #(
    parameter int NR_DRAIN_PORTS = 2
);
    logic                      flush_dcache_o;
    logic                      flush_icache_o;
    logic                      flush_ack_i;
    logic [NR_DRAIN_PORTS-1:0] busy_i;

    modport master (
        output flush_dcache_o,
        output flush_icache_o,
        input  flush_ack_i,
        input  busy_i
    );

    modport slave (
        input  flush_dcache_o,
        input  flush_icache_o,
        output flush_ack_i,
        output busy_i
    );
endinterface

// File: rtl/fence_t_sequencer_counter.sv
// rtl/fence_t_sequencer_counter.sv - generic clearable/loadable up/down counter
module fence_t_sequencer_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;

    // clear beats load, load beats count
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else if (clear_i) begin
            r_q <= '0;
        end else if (load_i) begin
            r_q <= d_i;
        end else if (en_i) begin
            r_q <= down_i ? (r_q - ONE) : (r_q + ONE);
        end
    end

    assign q_o = r_q;
endmodule

// File: rtl/fence_t_sequencer.sv
// rtl/fence_t_sequencer.sv - fence.t flush/drain/pad/micro-reset sequencer
module fence_t_sequencer
    import fence_t_sequencer_pkg::*;
#(
    parameter int VLEN           = 64,
    parameter int NR_DRAIN_PORTS = 2,
    parameter int DRAIN_CYCLES   = 16,
    parameter int RST_CYCLES     = 16,
    parameter int INIT_HOLD      = 3,
    parameter int NR_PAD_SRC     = 2,
    parameter int PAD_WIDTH      = 32,
    localparam int SEL_W         = (NR_PAD_SRC > 1) ? $clog2(NR_PAD_SRC) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fence_t_i,
    input  logic [VLEN-1:0]       pc_commit_i,
    input  logic [VLEN-1:0]       boot_addr_i,
    fence_t_sequencer_if.master   cache_if,
    input  logic [PAD_WIDTH-1:0]  pad_i,
    input  logic [SEL_W-1:0]      pad_src_sel_i,
    input  logic [NR_PAD_SRC-1:0] pad_trig_i,
    output logic                  halt_o,
    output logic                  stall_o,
    output logic                  rst_uarch_no,
    output logic                  cache_init_no,
    output logic [VLEN-1:0]       rst_addr_o,
    output logic [PAD_WIDTH-1:0]  ceil_o,
    output logic                  miss_o,
    output logic [MISS_CNT_W-1:0] miss_cnt_o
);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES);
    localparam int RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);

    fence_t_state_e        r_state;
    fence_t_state_e        w_state_next;
    logic                  r_flush_d;
    logic                  r_flush_i;
    logic                  r_armed;
    logic                  r_miss;
    logic                  r_miss_latch;
    miss_cnt_t             r_miss_cnt;
    logic [VLEN-1:0]       r_rst_addr;
    logic [PAD_WIDTH-1:0]  r_ceil;
    logic [RST_W-1:0]      r_rst_cnt;
    logic [INIT_HOLD-1:0]  r_init_sr;
    logic [NR_PAD_SRC-1:0] r_trig_q;

    logic [DRAIN_W-1:0]    w_drain_q;
    logic [PAD_WIDTH-1:0]  w_pad_q;
    logic                  w_any_busy;
    logic                  w_drain_done;
    logic                  w_pad_zero;
    logic                  w_rst_done;
    logic                  w_trig_edge;
    logic                  w_miss_evt;
    int                    w_sel_idx;

    assign w_any_busy   = |cache_if.busy_i;
    assign w_drain_done = (w_drain_q == DRAIN_LAST) && !w_any_busy;
    assign w_pad_zero   = (w_pad_q == '0);
    assign w_rst_done   = (r_rst_cnt == RST_LAST);
    assign w_miss_evt   = r_armed && w_pad_zero && !r_miss_latch &&
                          ((r_state == FLUSH) || (r_state == DRAIN));

    // consecutive all-idle cycles seen while draining
    fence_t_sequencer_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i ((r_state != DRAIN) || w_any_busy),
        .en_i    (w_drain_q != DRAIN_LAST),
        .load_i  (1'b0),
        .down_i  (1'b0),
        .d_i     ('0),
        .q_o     (w_drain_q)
    );

    // cycles remaining until the padding deadline
    fence_t_sequencer_counter #(.WIDTH(PAD_WIDTH)) u_pad_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (1'b0),
        .en_i    (!w_pad_zero),
        .load_i  (w_trig_edge),
        .down_i  (1'b1),
        .d_i     (pad_i),
        .q_o     (w_pad_q)
    );

    // select the trigger source (out of range falls back to 0) and detect its rising edge
    always_comb begin
        w_sel_idx   = 0;
        w_trig_edge = 1'b0;
        if (int'(pad_src_sel_i) < NR_PAD_SRC) begin
            w_sel_idx = int'(pad_src_sel_i);
        end
        for (int k = 0; k < NR_PAD_SRC; k++) begin
            if (k == w_sel_idx) begin
                w_trig_edge = pad_trig_i[k] & ~r_trig_q[k];
            end
        end
    end

    // next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (fence_t_i)            w_state_next = FLUSH;
            FLUSH:   if (cache_if.flush_ack_i) w_state_next = DRAIN;
            DRAIN:   if (w_drain_done)         w_state_next = PAD;
            PAD:     if (r_armed && w_pad_zero) w_state_next = RST;
            RST:     if (w_rst_done)           w_state_next = IDLE;
            default:                           w_state_next = IDLE;
        endcase
    end

    // state register plus per-fence bookkeeping
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_flush_d    <= 1'b0;
            r_flush_i    <= 1'b0;
            r_armed      <= 1'b0;
            r_miss       <= 1'b0;
            r_miss_latch <= 1'b0;
            r_miss_cnt   <= '0;
            r_rst_addr   <= boot_addr_i;
            r_ceil       <= '0;
            r_rst_cnt    <= '0;
            r_trig_q     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_flush_i <= 1'b0;
            r_miss    <= 1'b0;
            r_trig_q  <= pad_trig_i;

            case (r_state)
                IDLE: begin
                    if (fence_t_i) begin
                        r_flush_d    <= 1'b1;
                        r_flush_i    <= 1'b1;
                        r_rst_addr   <= pc_commit_i + VLEN'(4);
                        r_miss_latch <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (cache_if.flush_ack_i) begin
                        r_flush_d <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_ceil <= w_pad_zero ? '0 : (pad_i - w_pad_q);
                    end
                end
                default: ;
            endcase

            if ((r_state == IDLE) && fence_t_i) begin
                r_armed <= 1'b0;
            end else if (w_trig_edge && (r_state != IDLE)) begin
                r_armed <= 1'b1;
            end

            if (w_miss_evt) begin
                r_miss       <= 1'b1;
                r_miss_latch <= 1'b1;
                if (r_miss_cnt != MISS_CNT_MAX) begin
                    r_miss_cnt <= r_miss_cnt + miss_cnt_t'(1);
                end
            end

            if ((r_state == RST) && !w_rst_done) begin
                r_rst_cnt <= r_rst_cnt + RST_W'(1);
            end else begin
                r_rst_cnt <= '0;
            end
        end
    end

    // stretch cache-init suppression past the end of the micro-reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_init_sr <= '0;
        end else begin
            r_init_sr[0] <= (r_state == RST);
            for (int i = 1; i < INIT_HOLD; i++) begin
                r_init_sr[i] <= r_init_sr[i-1];
            end
        end
    end

    assign cache_if.flush_dcache_o = r_flush_d;
    assign cache_if.flush_icache_o = r_flush_i;
    assign halt_o        = (r_state != IDLE);
    assign stall_o       = (r_state == DRAIN) || (r_state == PAD) || (r_state == RST);
    assign rst_uarch_no  = (r_state != RST);
    assign cache_init_no = (r_state == RST) || (|r_init_sr);
    assign rst_addr_o    = r_rst_addr;
    assign ceil_o        = r_ceil;
    assign miss_o        = r_miss;
    assign miss_cnt_o    = r_miss_cnt;
endmodule
